int_issue_select_ctrl: RTL and testbench
========================================

// Module: int_issue_select_ctrl
// PURPOSE
//  Issue-select controller for the integer reservation station shift-register queue.
//  Tracks queue occupancy and drives issueque_full.
//  Picks the oldest ready entry (lowest index) and hands it to the issue block.
//  Sequences the issue-block handshake via issueblk_done.
//  Drives the queue's collapse (remove-and-shift) and dispatch write-slot controls.
// PARAMETERS
//  DEPTH  8               number of reservation station entries; index 0 = oldest
//  IDXW   $clog2(DEPTH)   entry index width
//  CNTW   $clog2(DEPTH+1) occupancy counter width
// PORTS
//  clk              in   1      rising-edge clock, the only clock
//  reset            in   1      synchronous, active-high reset
//  dispatch_enable  in   1      dispatch writes one new entry this cycle
//  entry_ready      in   DEPTH  entry valid and both operand data_val set (post-CDB)
//  issueblk_done    in   1      issue block finished the current op; accepts a new one this cycle
//  issueque_readyk  out  1      an entry is issued this cycle (grant valid)
//  issue_grant      out  DEPTH  one-hot entry being issued; 0 when issueque_readyk=0
//  collapse_en      out  1      queue removes the entry at collapse_idx; shifts older-than-tail down
//  collapse_idx     out  IDXW   index removed; equals the encoded issue_grant
//  write_idx        out  IDXW   slot the dispatched entry is written to this cycle
//  issueque_full    out  1      registered; count==DEPTH
//  occupancy        out  CNTW   registered entry count
//  dispatch_drop    out  1      registered 1-cycle pulse: dispatch_enable arrived while full, ignored
// BEHAVIOUR
//  FSM, 2 states:
//   IDLE: issue block free.
//   BUSY: an op is outstanding in the issue block.
//  Reset values (synchronous):
//   state=IDLE, occupancy=0, issueque_full=0, dispatch_drop=0.
//   Combinational outputs then read 0, except write_idx=0.
//  can_issue = (state==IDLE) | (state==BUSY & issueblk_done).
//  issueque_readyk = can_issue & |entry_ready. Combinational, 0-cycle latency from entry_ready.
//  issue_grant = lowest set bit of entry_ready when issueque_readyk, else 0.
//   Strict age priority; no fairness beyond age.
//  collapse_en = issueque_readyk; collapse_idx = index of issue_grant.
//  Transitions:
//   IDLE->BUSY on issue.
//   BUSY->IDLE on issueblk_done with no ready entry.
//   BUSY->BUSY on issueblk_done with a ready entry: back-to-back issue, no bubble.
//   BUSY->BUSY while issueblk_done=0.
//  issueblk_done in IDLE is ignored.
//  Dispatch accept: disp_ok = dispatch_enable & ~issueque_full.
//  dispatch_enable while full: dropped, no count change, dispatch_drop=1 next cycle.
//  write_idx = occupancy - issueque_readyk, truncated to IDXW.
//   The new entry lands behind the post-collapse tail.
//   If occupancy=0 and no issue, write_idx=0.
//  Occupancy next = occupancy + disp_ok - issueque_readyk.
//   Simultaneous dispatch and issue leaves count unchanged.
//   Never exceeds DEPTH; never underflows (issue requires a ready entry, hence occupancy>=1).
//  issueque_full next = (occupancy_next == DEPTH).
//   Full blocks dispatch in the same cycle an issue frees a slot.
//   The freed slot is usable from the next cycle (registered full).
//  Wrap-around: none; the queue is a collapsing shift register, so indices do not wrap.
//  Entry readiness from a CDB broadcast in cycle N is visible via entry_ready in N+1.
//   That timing is owned by the queue; this block adds no latency.
//  Reset mid-operation:
//   Outstanding BUSY op is abandoned, state=IDLE, occupancy=0.
//   The queue must clear its valid bits on the same reset.
//  Assertions:
//   $onehot0(issue_grant).
//   issue_grant subset of entry_ready.
//   occupancy<=DEPTH.
//   No issue when entry_ready==0.
// STRUCTURE
//  Shared package int_rs_pkg:
//   RS_DEPTH constant.
//   rs_idx_t and rs_cnt_t typedefs.
//   issue FSM state enum (ISS_IDLE, ISS_BUSY).
//  One sub-module: int_rs_prio_enc.
//   Parameterised lowest-index one-hot priority select plus binary encode.
//   Returns grant, index and any-valid.
//  Occupancy counter, full flag and FSM stay in this module.
// TESTING
//  1. Reset, then dispatch 3 entries, none ready -> occupancy=3, write_idx 0,1,2, issueque_readyk=0.
//  2. entry_ready=8'b0000_0110 in IDLE -> issue_grant=8'b0000_0010, collapse_idx=1.
//     Then BUSY; no further issue until issueblk_done.
//  3. BUSY, entry_ready=8'b0000_0001, issueblk_done=1 -> same-cycle grant of entry 0.
//     State stays BUSY; occupancy decrements by 1.
//  4. Fill to 8 -> issueque_full=1.
//     dispatch_enable plus issue in the same cycle -> dispatch dropped, dispatch_drop=1 next cycle.
//     occupancy=7, full=0 next cycle.
//  5. occupancy=4, issue and dispatch in the same cycle -> write_idx=3, occupancy stays 4.
//  6. reset asserted while BUSY with occupancy=5 -> next cycle: IDLE, occupancy=0, full=0.
//     issueblk_done then ignored.

Source files
------------

// File: rtl/int_rs_pkg.sv
// Shared types and sizing for the integer reservation station queue.
// The issue-select controller and its priority encoder import this package.
package int_rs_pkg;

    localparam int RS_DEPTH = 8;
    localparam int RS_IDXW  = $clog2(RS_DEPTH);
    localparam int RS_CNTW  = $clog2(RS_DEPTH + 1);

    typedef logic [RS_IDXW-1:0] rs_idx_t;
    typedef logic [RS_CNTW-1:0] rs_cnt_t;

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_BUSY = 1'b1
    } iss_state_t;

endpackage

// File: rtl/int_issue_select_ctrl_if.sv
// Controller <-> queue/issue-block signal bundle.
// The master side is the controller; the slave side is the queue and issue block.
interface int_issue_select_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic             dispatch_enable;
    logic [DEPTH-1:0] entry_ready;
    logic             issueblk_done;
    logic             issueque_readyk;
    logic [DEPTH-1:0] issue_grant;
    logic             collapse_en;
    logic [IDXW-1:0]  collapse_idx;
    logic [IDXW-1:0]  write_idx;
    logic             issueque_full;
    logic [CNTW-1:0]  occupancy;
    logic             dispatch_drop;

    modport master (
        input  dispatch_enable, entry_ready, issueblk_done,
        output issueque_readyk, issue_grant, collapse_en, collapse_idx,
               write_idx, issueque_full, occupancy, dispatch_drop
    );

    modport slave (
        output dispatch_enable, entry_ready, issueblk_done,
        input  issueque_readyk, issue_grant, collapse_en, collapse_idx,
               write_idx, issueque_full, occupancy, dispatch_drop
    );
endinterface

// File: rtl/int_rs_prio_enc.sv
// Lowest-index-wins one-hot select plus binary encode of the winner.
// Index 0 is the oldest entry, so this is a pure age-priority pick.
module int_rs_prio_enc #(
    parameter int WIDTH = 8,
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = req & (~req + WIDTH'(1));
    assign any   = |req;

    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/int_issue_select_ctrl.sv
// Issue-select controller: age-priority pick, issue-block handshake FSM,
// occupancy/full tracking and collapse/write-slot control for the RS queue.
module int_issue_select_ctrl
    import int_rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    int_issue_select_ctrl_if.master bus
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    iss_state_t       state;
    logic [CNTW-1:0]  occ;
    logic             full;
    logic             drop;

    logic [DEPTH-1:0] enc_grant;
    logic [IDXW-1:0]  enc_idx;
    logic             enc_any;
    logic             can_issue;
    logic             issue;
    logic             disp_ok;
    logic [CNTW-1:0]  occ_next;

    int_rs_prio_enc #(.WIDTH(DEPTH)) u_prio (
        .req   (bus.entry_ready),
        .grant (enc_grant),
        .idx   (enc_idx),
        .any   (enc_any)
    );

    // A completing op frees the issue block in the same cycle, so the next
    // ready entry goes out back-to-back.
    assign can_issue = (state == ISS_IDLE) | ((state == ISS_BUSY) & bus.issueblk_done);
    assign issue     = can_issue & enc_any;
    assign disp_ok   = bus.dispatch_enable & ~full;
    assign occ_next  = occ + CNTW'(disp_ok) - CNTW'(issue);

    assign bus.issueque_readyk = issue;
    assign bus.issue_grant     = issue ? enc_grant : '0;
    assign bus.collapse_en     = issue;
    assign bus.collapse_idx    = issue ? enc_idx : '0;
    // New entry lands just behind the tail as it stands after this cycle's collapse.
    assign bus.write_idx       = IDXW'(occ - CNTW'(issue));
    assign bus.issueque_full   = full;
    assign bus.occupancy       = occ;
    assign bus.dispatch_drop   = drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ISS_IDLE;
            occ   <= '0;
            full  <= 1'b0;
            drop  <= 1'b0;
        end else begin
            case (state)
                ISS_IDLE: if (issue) state <= ISS_BUSY;
                ISS_BUSY: if (bus.issueblk_done && !issue) state <= ISS_IDLE;
                default:  state <= ISS_IDLE;
            endcase
            occ  <= occ_next;
            full <= (occ_next == CNTW'(DEPTH));
            drop <= bus.dispatch_enable & full;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.issue_grant));
    a_grant_subset: assert property (@(posedge clk) disable iff (reset)
        (bus.issue_grant & ~bus.entry_ready) == '0);
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        occ <= CNTW'(DEPTH));
    a_no_spurious_issue: assert property (@(posedge clk) disable iff (reset)
        (bus.entry_ready == '0) |-> !issue);

endmodule

// File: tb/tb_int_issue_select_ctrl.sv
// Bench for int_issue_select_ctrl: directed vector table, hand sequences,
// then random traffic checked against a queue-level reference model.
module tb_int_issue_select_ctrl;

    localparam int DEPTH = 8;

    typedef struct {
        logic       rst;
        logic       disp;
        logic [7:0] rdy;
        logic       done;
        logic       rk;
        logic [7:0] gnt;
        int         cidx;
        int         widx;
        int         occ;
        logic       full;
        logic       drop;
    } vec_t;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    int_issue_select_ctrl_if #(.DEPTH(DEPTH)) bus ();

    int_issue_select_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic disp, input logic [7:0] rdy,
                                input logic done, input logic rk, input logic [7:0] gnt,
                                input int cidx, input int widx, input int occ,
                                input logic full, input logic drop);
        vec_t v;
        v.rst = rst; v.disp = disp; v.rdy = rdy; v.done = done;
        v.rk = rk; v.gnt = gnt; v.cidx = cidx; v.widx = widx;
        v.occ = occ; v.full = full; v.drop = drop;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check mid-cycle, then advance past the edge.
    task automatic run(input vec_t v);
        reset               = v.rst;
        bus.dispatch_enable = v.disp;
        bus.entry_ready     = v.rdy;
        bus.issueblk_done   = v.done;
        #3;
        chk("readyk",       int'(bus.issueque_readyk), int'(v.rk));
        chk("collapse_en",  int'(bus.collapse_en),     int'(v.rk));
        chk("issue_grant",  int'(bus.issue_grant),     int'(v.gnt));
        chk("collapse_idx", int'(bus.collapse_idx),    v.cidx);
        chk("write_idx",    int'(bus.write_idx),       v.widx);
        chk("occupancy",    int'(bus.occupancy),       v.occ);
        chk("full",         int'(bus.issueque_full),   int'(v.full));
        chk("drop",         int'(bus.dispatch_drop),   int'(v.drop));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    // Reference model: the queue as a list of entry ids, plus busy/full/drop flags.
    int   q[$];
    bit   busy, mfull, mdrop;
    int   next_id;

    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b1;
        bus.dispatch_enable = 1'b0;
        bus.entry_ready = '0;
        bus.issueblk_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        tbl.push_back(mk(0,0,8'h00,0, 0,8'h00,0,0,0,0,0));  // reset state
        tbl.push_back(mk(0,1,8'h00,0, 0,8'h00,0,0,0,0,0));
        tbl.push_back(mk(0,1,8'h00,0, 0,8'h00,0,1,1,0,0));
        tbl.push_back(mk(0,1,8'h00,0, 0,8'h00,0,2,2,0,0));
        tbl.push_back(mk(0,0,8'h00,0, 0,8'h00,0,3,3,0,0));
        tbl.push_back(mk(0,0,8'h06,0, 1,8'h02,1,2,3,0,0));  // oldest-ready pick
        tbl.push_back(mk(0,0,8'h03,0, 0,8'h00,0,2,2,0,0));  // busy blocks issue
        tbl.push_back(mk(0,0,8'h01,1, 1,8'h01,0,1,2,0,0));  // back-to-back
        tbl.push_back(mk(0,0,8'h00,1, 0,8'h00,0,1,1,0,0));  // busy -> idle
        for (int k = 1; k < 8; k++) tbl.push_back(mk(0,1,8'h00,0, 0,8'h00,0,k,k,0,0));
        tbl.push_back(mk(0,1,8'h01,0, 1,8'h01,0,7,8,1,0));  // full: dispatch dropped
        tbl.push_back(mk(0,0,8'h00,0, 0,8'h00,0,7,7,0,1));
        tbl.push_back(mk(0,0,8'h01,1, 1,8'h01,0,6,7,0,0));
        tbl.push_back(mk(0,0,8'h01,1, 1,8'h01,0,5,6,0,0));
        tbl.push_back(mk(0,0,8'h01,1, 1,8'h01,0,4,5,0,0));
        tbl.push_back(mk(0,1,8'h08,1, 1,8'h08,3,3,4,0,0));  // issue + dispatch
        tbl.push_back(mk(0,0,8'h00,0, 0,8'h00,0,4,4,0,0));
        tbl.push_back(mk(0,1,8'h00,0, 0,8'h00,0,4,4,0,0));
        tbl.push_back(mk(1,0,8'h00,0, 0,8'h00,0,5,5,0,0));  // reset while busy
        tbl.push_back(mk(0,0,8'h00,1, 0,8'h00,0,0,0,0,0));
        tbl.push_back(mk(0,1,8'h00,0, 0,8'h00,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h01,0, 1,8'h01,0,0,1,0,0));  // idle after reset
        tbl.push_back(mk(0,0,8'h00,0, 0,8'h00,0,0,0,0,0));
        foreach (tbl[i]) run(tbl[i]);

        // Fill with nothing ready, then keep dispatching into a full queue.
        run(mk(1,0,8'h00,0, 0,8'h00,0,0,0,0,0));
        for (int k = 0; k < 8; k++) run(mk(0,1,8'h00,0, 0,8'h00,0,k,k,0,0));
        run(mk(0,1,8'h00,0, 0,8'h00,0,0,8,1,0));
        run(mk(0,1,8'h00,0, 0,8'h00,0,0,8,1,1));
        run(mk(0,0,8'h00,0, 0,8'h00,0,0,8,1,1));
        run(mk(1,0,8'h00,0, 0,8'h00,0,0,8,1,0));

        q.delete();
        busy = 0; mfull = 0; mdrop = 0; next_id = 0;
        for (int n = 0; n < 600; n++) begin
            vec_t v;
            int pick;
            bit ok;
            v.rst  = ($urandom_range(0, 79) == 0);
            v.disp = ($urandom_range(0, 99) < 55);
            v.done = ($urandom_range(0, 1) == 1);
            v.rdy  = '0;
            for (int i = 0; i < q.size(); i++) v.rdy[i] = ($urandom_range(0, 9) < 3);
            pick = -1;
            for (int i = q.size() - 1; i >= 0; i--) if (v.rdy[i]) pick = i;
            v.rk   = (!busy || v.done) && (pick >= 0);
            v.gnt  = '0;
            if (v.rk) v.gnt[pick] = 1'b1;
            v.cidx = v.rk ? pick : 0;
            v.widx = (q.size() - int'(v.rk)) % DEPTH;
            v.occ  = q.size();
            v.full = mfull;
            v.drop = mdrop;
            run(v);
            if (v.rst) begin
                q.delete();
                busy = 0; mfull = 0; mdrop = 0;
            end else begin
                ok = v.disp && !mfull;
                mdrop = v.disp && mfull;
                if (v.rk) q.delete(pick);
                busy = v.rk || (busy && !v.done);
                if (ok) begin
                    q.push_back(next_id);
                    next_id++;
                end
                mfull = (q.size() == DEPTH);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
